// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: RV32I front end. Owns the PC, fetches one instruction per
// imem req/ack transaction, presents the instruction and its decoded fields,
// and applies PCSel from the control unit to pick the next PC.
// Optional feature: define FETCH_TIMEOUT_EN to bound the wait for imem_ack.
// With it defined, a fetch that runs out of time sets the sticky fetch_err and
// parks the unit in TRAP. With it undefined, fetch_err is tied low.
//
// Handshake: imem_req rises in FETCH. imem_req and imem_addr then stay stable
// until the cycle in which imem_ack=1 is sampled. imem_ack is ignored whenever
// imem_req=0. On the downstream side, an instruction is consumed on a rising
// edge where inst_valid=1 and stall=0.
module inst_fetch_unit #(
  parameter int unsigned      XLEN          = 32,
  parameter logic [XLEN-1:0]  RESET_PC      = '0,
  parameter int unsigned      FETCH_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,       // synchronous, active-high
  input  logic            stall,
  input  logic [1:0]      PCSel,
  input  logic [XLEN-1:0] alu_result,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
  output logic            fetch_err,
  output logic [31:0]     inst_count,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     inst_count_q, inst_count_d;
  logic [XLEN-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned     TW      = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(FETCH_TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          fetch_err_q, fetch_err_d;
`endif

  // Next-PC selection. JALR clears bit 0, but bit 1 is still checked for
  // alignment. Additions wrap naturally at 2^XLEN.
  always_comb begin
    next_pc = pc_q + XLEN'(4);
    case (PCSel)
      2'd1:    next_pc = alu_result;
      2'd2:    next_pc = {alu_result[XLEN-1:1], 1'b0};
      default: next_pc = pc_q + XLEN'(4);
    endcase
  end

  // FSM next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    misaligned_d = misaligned_q;
    inst_count_d = inst_count_q;
`ifdef FETCH_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    fetch_err_d  = fetch_err_q;
`endif
    case (state_q)
      ST_RST: begin
        // Any ack still in flight from before reset is dropped here.
        state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_VALID;
`ifdef FETCH_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          // An ack in the final cycle takes priority over the error.
          fetch_err_d = 1'b1;
          state_d     = ST_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
`endif
        end
      end
      ST_VALID: begin
        if (!stall) begin
          inst_count_d = inst_count_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = ST_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      default: begin
        // TRAP stays parked until reset.
        state_d = ST_TRAP;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      misaligned_q <= 1'b0;
      inst_count_q <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_q     <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misaligned_q <= misaligned_d;
      inst_count_q <= inst_count_d;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ST_VALID);
  assign inst       = inst_q;
  assign opcode     = inst_q[6:0];
  assign funct3     = inst_q[14:12];
  assign funct7     = inst_q[31:25];
  assign pc_out     = pc_q;
  assign pc_plus4   = pc_q + XLEN'(4);
  assign misaligned = misaligned_q;
  assign inst_count = inst_count_q;
  assign state_dbg  = state_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = fetch_err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit: reset, sequential fetch, stall hold,
// branch/JALR targets, misalignment trap, reset during fetch, PC wrap and the
// fetch-wait behaviour with and without FETCH_TIMEOUT_EN.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  PCSel;
  logic [31:0] alu_result;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        fetch_err;
  logic [31:0] inst_count;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_RST = 2'd0, S_FETCH = 2'd1, S_VALID = 2'd2, S_TRAP = 2'd3;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .PCSel(PCSel),
    .alu_result(alu_result), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .misaligned(misaligned),
    .fetch_err(fetch_err), .inst_count(inst_count), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, ack it with zero wait,
  // and check the latched instruction.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step();
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_inst"}, inst, rdata);
    check({tag, "_pc"}, pc_out, exp_addr);
  endtask

  // Consume the presented instruction with the given next-PC select.
  task automatic consume(input logic [1:0] sel, input logic [31:0] alu);
    PCSel      = sel;
    alu_result = alu;
    stall      = 1'b0;
    step();
    stall      = 1'b1;
    PCSel      = 2'd0;
    alu_result = 32'h0;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b1; PCSel = 2'd0; alu_result = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset state
    repeat (3) step();
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_RST});
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    check("rst_ferr", {31'd0, fetch_err}, 32'd0);
    check("rst_cnt", inst_count, 32'd0);

    // Release: first request one cycle later, ack in the same cycle
    rst_n = 1'b0;
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
    do_fetch("f0", 32'h0, 32'h0050_0093);   // addi x1,x0,5
    check("f0_opcode", {25'd0, opcode}, 32'h13);
    check("f0_funct3", {29'd0, funct3}, 32'd0);
    check("f0_pc4", pc_plus4, 32'h4);

    // Sequential PC+4 fetches
    consume(2'd0, 32'h0);
    do_fetch("f4", 32'h4, 32'h0020_81B3);   // add x3,x1,x2
    check("f4_opcode", {25'd0, opcode}, 32'h33);
    consume(2'd0, 32'h0);
    do_fetch("f8", 32'h8, 32'h4020_8233);   // sub x4,x1,x2
    check("f8_funct7", {25'd0, funct7}, 32'h20);
    consume(2'd0, 32'h0);
    check("cnt3", inst_count, 32'd3);
    do_fetch("fc", 32'hC, 32'h0000_0013);
    consume(2'd0, 32'h0);
    do_fetch("f10", 32'h10, 32'h0020_9463); // bne x1,x2,8
    check("f10_funct3", {29'd0, funct3}, 32'd1);
    check("f10_opcode", {25'd0, opcode}, 32'h63);

    // Stall holds everything, even with a target presented
    PCSel = 2'd1; alu_result = 32'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h0020_9463);
      check("stall_pc", pc_out, 32'h10);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    check("stall_cnt", inst_count, 32'd4);
    consume(2'd1, 32'h40);
    check("br_cnt", inst_count, 32'd5);
    do_fetch("f40", 32'h40, 32'h0080_00E7); // jalr x1,8(x0)

    // JALR clears bit 0
    consume(2'd2, 32'h81);
    do_fetch("f80", 32'h80, 32'h0000_0013);

    // Branch to a half-word address traps
    consume(2'd1, 32'h82);
    check("trap_state", {30'd0, state_dbg}, {30'd0, S_TRAP});
    check("trap_mis", {31'd0, misaligned}, 32'd1);
    check("trap_valid", {31'd0, inst_valid}, 32'd0);
    check("trap_cnt", inst_count, 32'd7);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    repeat (4) step();
    imem_ack = 1'b0;
    check("trap_req", {31'd0, imem_req}, 32'd0);
    check("trap_mis_hold", {31'd0, misaligned}, 32'd1);
    check("trap_inst_hold", inst, 32'h0000_0013);

    // Reset during FETCH with an ack arriving while in RST
    rst_n = 1'b1; step();
    rst_n = 1'b0; step();
    check("rf_req", {31'd0, imem_req}, 32'd1);
    step();
    rst_n = 1'b1; step();
    check("rf_state", {30'd0, state_dbg}, {30'd0, S_RST});
    check("rf_mis_clr", {31'd0, misaligned}, 32'd0);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("rf_ack_ignored", inst, 32'h0000_0013);
    check("rf_valid", {31'd0, inst_valid}, 32'd0);
    check("rf_restart_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
    do_fetch("rf0", 32'h0, 32'h0010_0093);
    check("rf_cnt", inst_count, 32'd0);

    // PC wrap at the top of the address space, and reserved PCSel=3
    consume(2'd1, 32'hFFFF_FFFC);
    do_fetch("ftop", 32'hFFFF_FFFC, 32'h0000_0013);
    check("ftop_pc4", pc_plus4, 32'h0);
    consume(2'd0, 32'h0);
    do_fetch("fwrap", 32'h0, 32'h0000_0013);
    consume(2'd3, 32'h100);
    do_fetch("fsel3", 32'h4, 32'h0000_0013);
    check("wrap_cnt", inst_count, 32'd3);

`ifdef FETCH_TIMEOUT_EN
    // No ack: 16 FETCH cycles, then error and TRAP
    consume(2'd0, 32'h0);             // FETCH cycle 1 at 0x8
    repeat (15) step();               // FETCH cycle 16
    check("to_still_req", {31'd0, imem_req}, 32'd1);
    check("to_no_err_yet", {31'd0, fetch_err}, 32'd0);
    step();
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_req_drop", {31'd0, imem_req}, 32'd0);
    check("to_state", {30'd0, state_dbg}, {30'd0, S_TRAP});
    // Ack exactly on cycle 16 wins
    rst_n = 1'b1; step();
    rst_n = 1'b0; step();             // FETCH cycle 1
    repeat (15) step();               // FETCH cycle 16
    imem_ack = 1'b1; imem_rdata = 32'h0000_0513;
    step();
    imem_ack = 1'b0;
    check("to16_err", {31'd0, fetch_err}, 32'd0);
    check("to16_valid", {31'd0, inst_valid}, 32'd1);
    check("to16_inst", inst, 32'h0000_0513);
`else
    // Without the timeout, FETCH waits indefinitely
    consume(2'd0, 32'h0);
    repeat (40) step();
    check("wait_req", {31'd0, imem_req}, 32'd1);
    check("wait_ferr", {31'd0, fetch_err}, 32'd0);
    do_fetch("late", 32'h8, 32'h0000_0513);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=sim_running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the single-issue RV32I core. Owns the PC register and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the fetched instruction and its decoded fields (opcode, funct3, funct7) to the control unit.
- Consumes the control unit's PCSel and the ALU target to select the next PC. It is the receiving end of the PCSel interface.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FETCH_TIMEOUT, 16, max FETCH cycles awaiting imem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; the instruction is consumed only when inst_valid=1 and stall=0
- PCSel  in  2  next-PC select from the control unit: 0=PC+4, 1=branch target, 2=jump target, 3=reserved
- alu_result  in  XLEN  target address for PCSel 1/2
- imem_req  out  1  instruction memory read request
- imem_addr  out  XLEN  read address, word aligned
- imem_ack  in  1  read data valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst, opcode, funct3, funct7, pc_out valid
- inst  out  32  latched instruction
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- pc_out  out  XLEN  PC of the latched instruction
- pc_plus4  out  XLEN  pc_out+4 (mod 2^XLEN), for WB select
- misaligned  out  1  sticky: next PC not word aligned
- fetch_err  out  1  sticky: fetch timeout (optional feature only; tied 0 otherwise)
- inst_count  out  32  retired-instruction counter

Behaviour:
- States: RST, FETCH, VALID, TRAP. All registers update only on the rising clk edge.
- Reset (rst_n=1 sampled high), regardless of current state:
  - state=RST, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - inst=32'h0000_0013 (NOP), inst_valid=0.
  - misaligned=0, fetch_err=0, inst_count=0.
- RST: next cycle goes to FETCH. imem_ack is ignored in RST, which discards a response that was in flight when reset hit.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until ack.
  - An ack in the first FETCH cycle is legal.
  - On imem_ack=1: inst<=imem_rdata, go to VALID.
  - imem_ack while imem_req=0 is ignored.
- VALID:
  - inst_valid=1, imem_req=0.
  - While stall=1: hold all outputs.
  - When stall=0 (consume): compute next_pc, increment inst_count (wraps 0xFFFF_FFFF->0), then apply the first matching rule:
    - next_pc[1:0]!=0: set misaligned=1, go to TRAP.
    - otherwise: pc<=next_pc, go to FETCH.
- next_pc selection:
  - PCSel 0 or 3: pc+4.
  - PCSel 1: alu_result.
  - PCSel 2: alu_result with bit0 forced to 0 (JALR rule). Bit1 is still checked.
  - PC arithmetic wraps at 2^XLEN (0xFFFF_FFFC+4=0).
- TRAP: inst_valid=0, imem_req=0, no fetches. Exits only via reset.
- Field outputs (opcode, funct3, funct7) are combinational slices of the inst register. pc_out=pc. pc_plus4=pc+4.
- Throughput: with zero-wait ack and no stall, one instruction per 2 cycles.
- Latency: reset release to first imem_req is 1 cycle.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the count reaches FETCH_TIMEOUT with no ack: fetch_err=1 (sticky), imem_req drops, go to TRAP.
  - An ack in the same cycle as the limit wins; no error is raised.
- Undefined: no counter; FETCH waits indefinitely; fetch_err tied to 0.

Test Plan:
- Reset release, ack same cycle as req, rdata=0x00500093 -> cycle 1 imem_req=1, imem_addr=0x0; next cycle inst_valid=1, opcode=0x13, funct3=0, pc_plus4=0x4.
- Consume with PCSel=0 three times, no stall -> fetch addresses 0x0, 0x4, 0x8; inst_count=3.
- At pc=0x10: stall=1 for 5 cycles, then PCSel=1, alu_result=0x40 -> outputs frozen during stall; next imem_addr=0x40.
- PCSel=2, alu_result=0x81 -> next imem_addr=0x80. Then PCSel=1, alu_result=0x82 -> misaligned=1, TRAP, imem_req stays 0.
- rst_n=1 asserted mid-FETCH while ack pending, ack arrives in RST -> ack ignored; fetch restarts at RESET_PC with inst_valid=0.
- FETCH_TIMEOUT_EN defined, FETCH_TIMEOUT=16, no ack -> after 16 FETCH cycles fetch_err=1, imem_req=0. Repeat with ack on cycle 16 -> no error, inst latched.
